seg7_pattern_decoder: RTL and testbench
=======================================

Name: seg7_pattern_decoder

Overview:
- Receive-side counterpart of the team's 7-segment encoder: samples a 7-bit segment pattern bus and recovers the hex digit or alphabet code that produced it.
- Filters glitches with a consecutive-sample stability counter, emits one valid pulse per stable symbol, and flags unknown patterns.
- Sits between a segment-bus source (board SEG lines or the encoder output in loopback) and the LED/LCD debug outputs of top.

Parameters:
- STABLE_CYCLES, 4, consecutive identical accepted samples required to lock a symbol; legal range 2..255.
- NSEG, 7, segment bus width; bit0=a … bit6=g; fixed at 7.

Ports:
- clk_2  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous reset, active-low; sampled on rising edge of clk_2.
- sample_en  in  1  a sample is accepted on each edge where this is 1; when 0, all state holds.
- mode  in  1  0 = hex table (codes 0..15); 1 = alphabet table (codes 16..41).
- seg_in  in  NSEG  segment pattern, active-high.
- code  out  6  last decoded code; 63 = dash or unknown.
- valid  out  1  one-cycle pulse: a new symbol has locked.
- err  out  1  qualified by valid; 1 = locked pattern not in the active table.
- locked  out  1  a symbol is currently locked.
- sym_count  out  8  count of valid pulses with err=0; wraps 255 -> 0.

Behaviour:
- Reset (reset_n=0 at an edge): code=0, valid=0, err=0, locked=0, sym_count=0, run counter=0, held pattern=0, state=IDLE. Reset overrides every other input, including mid-run or while LOCKED.
- States:
  - IDLE: no pattern held.
  - SETTLE: counting consecutive identical samples.
  - LOCKED: symbol emitted, waiting for the pattern to change.
- Accepted sample, pattern 7'h00 (blank): from any state go to IDLE; run=0; locked=0; no valid.
- Accepted sample, non-blank, equal to held pattern:
  - In SETTLE: run=run+1.
  - If the new run equals STABLE_CYCLES: go to LOCKED and assert valid/err/code at that same edge.
  - In LOCKED: no change; no re-emission.
- Accepted sample, non-blank, different from held pattern (or state IDLE): held pattern=seg_in, run=1, state=SETTLE, locked=0.
- Latency: with the same pattern accepted on edges 1..N (N=STABLE_CYCLES), valid is high for exactly the cycle after edge N. locked rises at the same edge and stays high while in LOCKED.
- valid is deasserted on every edge where it is not being set. code and err hold their values until the next lock.
- mode is sampled only at the locking edge. Changing mode while LOCKED does not re-emit.
- Hex table (mode=0), pattern hex -> code: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->10, 7C->11, 39->12, 5E->13, 79->14, 71->15.
- Alphabet table (mode=1), pattern hex -> code: 77->16 A, 7C->17 b, 39->18 C, 58->19 c, 5E->20 d, 79->21 E, 71->22 F, 6F->23 g, 76->24 H, 74->25 h, 06->26 I, 04->27 i, 1E->28 J, 38->29 L, 54->30 n, 3F->31 O, 5C->32 o, 73->33 P, 67->34 q, 50->35 r, 6D->36 S, 78->37 t, 3E->38 U, 1C->39 u, 6E->40 y, 63->41 º.
- Dash 7'h40 (encoder default) in either mode: code=63, err=0, counted in sym_count.
- Any other pattern, or a pattern absent from the active table: code=63, err=1, not counted.
- sample_en=0 freezes run, state and held pattern. The stability run is not broken by gaps; only accepted samples count.
- Run counter width is clog2(STABLE_CYCLES+1). It never exceeds STABLE_CYCLES.

Test Plan:
- Reset then mode=0, seg_in=7'h5B held with sample_en=1 for 6 edges -> exactly one valid pulse, in the cycle after edge 4; code=2, err=0, locked=1, sym_count=1.
- seg_in alternates 7'h06/7'h07 every cycle for 20 edges, then 7'h07 held 4 edges -> no valid during alternation; a single valid with code=7; sym_count=1.
- mode=1, lock 7'h06, return to 7'h00 for 1 edge, lock 7'h06 again -> two valids, both code=26; sym_count=2. Repeat with mode=0 -> code=1.
- mode=0, lock 7'h76 -> valid, code=63, err=1, sym_count unchanged. Then lock 7'h40 -> code=63, err=0, sym_count+1.
- seg_in=7'h7F: 2 accepted edges, sample_en=0 for 5 edges, 2 more accepted edges -> valid after the 4th accepted edge, code=8.
- Lock 7'h6D, pull reset_n=0 for one edge, release with 7'h6D present -> all outputs 0 after reset; a fresh 4-edge run is required before valid (code=5).
- Counter wrap: 256 error-free locks -> sym_count returns to 0.

Source files
------------

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: recovers hex/alphabet codes from a sampled 7-segment pattern bus
// Ports:
//   i_clk_2       system clock, all state on rising edge
//   i_reset_n     synchronous active-low reset
//   i_sample_en   accept a sample on this edge; state holds when low
//   i_mode        0 = hex table (0..15), 1 = alphabet table (16..41)
//   i_seg_in      active-high segment pattern, bit0 = a ... bit6 = g
//   o_code        last decoded code, 63 = dash or unknown
//   o_valid       one-cycle pulse when a new symbol locks
//   o_err         qualified by o_valid, locked pattern not in active table
//   o_locked      a symbol is currently locked
//   o_sym_count   count of error-free locks, wraps at 256
module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int NSEG          = 7
) (
    input  logic            i_clk_2,
    input  logic            i_reset_n,
    input  logic            i_sample_en,
    input  logic            i_mode,
    input  logic [NSEG-1:0] i_seg_in,
    output logic [5:0]      o_code,
    output logic            o_valid,
    output logic            o_err,
    output logic            o_locked,
    output logic [7:0]      o_sym_count
);
    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] LOCK_RUN = RW'(STABLE_CYCLES);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam logic [6:0] DASH   = 7'h40;
    localparam logic [5:0] NONE   = 6'd63;

    logic [1:0]      r_state;
    logic [RW-1:0]   r_run;
    logic [NSEG-1:0] r_pat;
    logic [5:0]      r_code;
    logic            r_valid;
    logic            r_err;
    logic            r_locked;
    logic [7:0]      r_sym_count;
    logic [5:0]      w_hex;
    logic [5:0]      w_alpha;
    logic [5:0]      w_code;
    logic            w_err;
    logic [RW-1:0]   w_run_next;

    always_comb begin
        w_hex = NONE;
        case (i_seg_in)
            7'h3F: w_hex = 6'd0;
            7'h06: w_hex = 6'd1;
            7'h5B: w_hex = 6'd2;
            7'h4F: w_hex = 6'd3;
            7'h66: w_hex = 6'd4;
            7'h6D: w_hex = 6'd5;
            7'h7D: w_hex = 6'd6;
            7'h07: w_hex = 6'd7;
            7'h7F: w_hex = 6'd8;
            7'h6F: w_hex = 6'd9;
            7'h77: w_hex = 6'd10;
            7'h7C: w_hex = 6'd11;
            7'h39: w_hex = 6'd12;
            7'h5E: w_hex = 6'd13;
            7'h79: w_hex = 6'd14;
            7'h71: w_hex = 6'd15;
            default: w_hex = NONE;
        endcase
    end

    always_comb begin
        w_alpha = NONE;
        case (i_seg_in)
            7'h77: w_alpha = 6'd16;
            7'h7C: w_alpha = 6'd17;
            7'h39: w_alpha = 6'd18;
            7'h58: w_alpha = 6'd19;
            7'h5E: w_alpha = 6'd20;
            7'h79: w_alpha = 6'd21;
            7'h71: w_alpha = 6'd22;
            7'h6F: w_alpha = 6'd23;
            7'h76: w_alpha = 6'd24;
            7'h74: w_alpha = 6'd25;
            7'h06: w_alpha = 6'd26;
            7'h04: w_alpha = 6'd27;
            7'h1E: w_alpha = 6'd28;
            7'h38: w_alpha = 6'd29;
            7'h54: w_alpha = 6'd30;
            7'h3F: w_alpha = 6'd31;
            7'h5C: w_alpha = 6'd32;
            7'h73: w_alpha = 6'd33;
            7'h67: w_alpha = 6'd34;
            7'h50: w_alpha = 6'd35;
            7'h6D: w_alpha = 6'd36;
            7'h78: w_alpha = 6'd37;
            7'h3E: w_alpha = 6'd38;
            7'h1C: w_alpha = 6'd39;
            7'h6E: w_alpha = 6'd40;
            7'h63: w_alpha = 6'd41;
            default: w_alpha = NONE;
        endcase
    end

    // Dash is a legal symbol in both tables; any other miss is an error
    assign w_code     = (i_seg_in == DASH) ? NONE : (i_mode ? w_alpha : w_hex);
    assign w_err      = (i_seg_in != DASH) && (w_code == NONE);
    assign w_run_next = r_run + RW'(1);

    always_ff @(posedge i_clk_2) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_run       <= '0;
            r_pat       <= '0;
            r_code      <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
            r_sym_count <= '0;
        end else begin
            r_valid <= 1'b0;
            if (i_sample_en) begin
                if (i_seg_in == '0) begin
                    r_state  <= IDLE;
                    r_run    <= '0;
                    r_pat    <= '0;
                    r_locked <= 1'b0;
                end else if (r_state != IDLE && i_seg_in == r_pat) begin
                    // LOCKED with the same pattern holds silently
                    if (r_state == SETTLE) begin
                        r_run <= w_run_next;
                        if (w_run_next == LOCK_RUN) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                            r_valid  <= 1'b1;
                            r_code   <= w_code;
                            r_err    <= w_err;
                            if (!w_err) r_sym_count <= r_sym_count + 8'd1;
                        end
                    end
                end else begin
                    r_pat    <= i_seg_in;
                    r_run    <= RW'(1);
                    r_state  <= SETTLE;
                    r_locked <= 1'b0;
                end
            end
        end
    end

    assign o_code      = r_code;
    assign o_valid     = r_valid;
    assign o_err       = r_err;
    assign o_locked    = r_locked;
    assign o_sym_count = r_sym_count;
endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// tb_seg7_pattern_decoder: randomized and directed check of seg7_pattern_decoder against a table model
module tb_seg7_pattern_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [6:0] seg = '0;
    logic [5:0] o_code;
    logic       o_valid;
    logic       o_err;
    logic       o_locked;
    logic [7:0] o_sym_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;

    logic [6:0] hex_p[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] alpha_p[26] = '{7'h77, 7'h7C, 7'h39, 7'h58, 7'h5E, 7'h79, 7'h71, 7'h6F,
                                7'h76, 7'h74, 7'h06, 7'h04, 7'h1E, 7'h38, 7'h54, 7'h3F,
                                7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h1C,
                                7'h6E, 7'h63};

    int m_pat, m_run, m_code, m_sym;
    bit m_locked, m_valid, m_err;

    seg7_pattern_decoder dut (
        .i_clk_2    (clk),
        .i_reset_n  (rst_n),
        .i_sample_en(en),
        .i_mode     (mode),
        .i_seg_in   (seg),
        .o_code     (o_code),
        .o_valid    (o_valid),
        .o_err      (o_err),
        .o_locked   (o_locked),
        .o_sym_count(o_sym_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lookup(input bit m, input logic [6:0] s);
        if (s == 7'h40) return 63;
        if (m) begin
            for (int i = 0; i < 26; i++) if (alpha_p[i] == s) return 16 + i;
        end else begin
            for (int i = 0; i < 16; i++) if (hex_p[i] == s) return i;
        end
        return 63;
    endfunction

    task automatic model(input logic r, input logic e, input logic m, input logic [6:0] s);
        if (!r) begin
            m_pat = -1; m_run = 0; m_code = 0; m_sym = 0;
            m_locked = 0; m_valid = 0; m_err = 0;
            return;
        end
        m_valid = 0;
        if (!e) return;
        if (s == 0) begin
            m_pat = -1; m_run = 0; m_locked = 0;
        end else if (int'(s) == m_pat) begin
            if (!m_locked) begin
                m_run++;
                if (m_run == 4) begin
                    m_locked = 1;
                    m_valid  = 1;
                    m_code   = lookup(m, s);
                    m_err    = (s != 7'h40) && (m_code == 63);
                    if (!m_err) m_sym = (m_sym + 1) % 256;
                end
            end
        end else begin
            m_pat = int'(s); m_run = 1; m_locked = 0;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic m, input logic [6:0] s);
        @(negedge clk);
        rst_n = r; en = e; mode = m; seg = s;
        @(posedge clk);
        model(r, e, m, s);
        #1;
        if (o_valid === 1'b1) n_valid++;
        check("valid", o_valid, m_valid);
        check("locked", o_locked, m_locked);
        check("code", o_code, m_code);
        check("err", o_err, m_err);
        check("sym_count", o_sym_count, m_sym);
    endtask

    task automatic hold(input logic m, input logic [6:0] s, input int n);
        repeat (n) step(1'b1, 1'b1, m, s);
    endtask

    initial begin
        int v0, s0;
        logic [6:0] p;
        step(1'b0, 1'b0, 1'b0, 7'h00);
        step(1'b0, 1'b1, 1'b0, 7'h5B);

        v0 = n_valid;
        hold(1'b0, 7'h5B, 6);
        check("t1_pulses", n_valid - v0, 1);
        check("t1_code", o_code, 2);
        check("t1_sym", o_sym_count, 1);

        v0 = n_valid;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, (i % 2) ? 7'h07 : 7'h06);
        check("t2_alt_pulses", n_valid - v0, 0);
        hold(1'b0, 7'h07, 3);
        check("t2_pulses", n_valid - v0, 1);
        check("t2_code", o_code, 7);

        v0 = n_valid;
        hold(1'b1, 7'h00, 1); hold(1'b1, 7'h06, 4); hold(1'b1, 7'h00, 1); hold(1'b1, 7'h06, 4);
        check("t3_pulses", n_valid - v0, 2);
        check("t3_code", o_code, 26);
        hold(1'b0, 7'h00, 1); hold(1'b0, 7'h06, 4);
        check("t3_hex_code", o_code, 1);

        s0 = o_sym_count;
        hold(1'b0, 7'h76, 4);
        check("t4_err", o_err, 1);
        check("t4_sym", o_sym_count, s0);
        hold(1'b0, 7'h40, 4);
        check("t4_dash_code", o_code, 63);
        check("t4_dash_sym", o_sym_count, (s0 + 1) % 256);

        v0 = n_valid;
        hold(1'b0, 7'h7F, 2);
        repeat (5) step(1'b1, 1'b0, 1'b0, 7'h7F);
        hold(1'b0, 7'h7F, 1);
        check("t5_early", n_valid - v0, 0);
        hold(1'b0, 7'h7F, 1);
        check("t5_code", o_code, 8);
        check("t5_valid", o_valid, 1);

        hold(1'b0, 7'h6D, 4);
        step(1'b0, 1'b1, 1'b0, 7'h6D);
        check("t6_sym", o_sym_count, 0);
        v0 = n_valid;
        hold(1'b0, 7'h6D, 3);
        check("t6_early", n_valid - v0, 0);
        hold(1'b0, 7'h6D, 1);
        check("t6_code", o_code, 5);

        step(1'b0, 1'b1, 1'b0, 7'h00);
        for (int i = 0; i < 256; i++) hold(1'b0, (i % 2) ? 7'h06 : 7'h3F, 4);
        check("t7_wrap", o_sym_count, 0);

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0: p = hex_p[$urandom_range(0, 15)];
                1: p = alpha_p[$urandom_range(0, 25)];
                2: p = 7'($urandom);
                default: p = ($urandom_range(0, 1) != 0) ? 7'h40 : 7'h00;
            endcase
            for (int j = $urandom_range(1, 7); j > 0; j--)
                step(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0),
                     1'($urandom), p);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
